// File: rtl/tbird_pkg.sv
// Shared definitions for the Thunderbird request scheduler.
// Holds command codes, FSM state encodings, pending-bit indices and
// the arbitration helpers used by tbird_sched.
package tbird_pkg;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_LEFT  = 2'd1,
        CMD_RIGHT = 2'd2,
        CMD_HAZ   = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_ABORT  = 2'd3
    } state_t;

    localparam int SRC_LEFT  = 0;
    localparam int SRC_RIGHT = 1;
    localparam int SRC_HAZ   = 2;

    // Hazard beats everything; LEFT vs RIGHT is settled by the round-robin
    // pointer only when both are waiting.
    function automatic cmd_t pick_cmd(input logic [2:0] pend, input logic rr_right);
        if (pend[SRC_HAZ])                        return CMD_HAZ;
        if (pend[SRC_LEFT] && pend[SRC_RIGHT])    return rr_right ? CMD_RIGHT : CMD_LEFT;
        if (pend[SRC_LEFT])                       return CMD_LEFT;
        if (pend[SRC_RIGHT])                      return CMD_RIGHT;
        return CMD_NONE;
    endfunction

    // Pending-bit mask that belongs to a command code.
    function automatic logic [2:0] cmd_mask(input cmd_t c);
        case (c)
            CMD_LEFT:  return 3'b001;
            CMD_RIGHT: return 3'b010;
            CMD_HAZ:   return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/tbird_debounce.sv
// Switch conditioner: 2-FF synchronizer, DB_LEN-sample stability debouncer,
// registered rising-edge pulse of the debounced level.
// Ports: i_clk, i_rst (sync, active-high), sw (raw async level), rise (1-cycle pulse).
module tbird_debounce #(
    parameter int DB_LEN = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic sw,
    output logic rise
);
    localparam int             CW       = (DB_LEN > 1) ? $clog2(DB_LEN) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_LEN - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
            rise    <= 1'b0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
            // The level flips on the DB_LEN-th consecutive differing sample;
            // any agreeing sample restarts the run.
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
            level_q <= level;
            rise    <= level & ~level_q;
        end
    end

endmodule

// File: rtl/tbird_sched.sv
// Request scheduler for the tail-light sequencer: conditions three switches,
// queues one request per source, arbitrates, issues via valid/ready, makes the
// step tick and aborts on hazard preemption or timeout. All outputs registered.
module tbird_sched
    import tbird_pkg::*;
#(
    parameter int TICK_DIV  = 25000000,
    parameter int DB_LEN    = 4,
    parameter int MAX_TICKS = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sw_left,
    input  logic       i_sw_right,
    input  logic       i_sw_haz,
    input  logic       i_cmd_ready,
    input  logic       i_seq_done,
    output logic       o_cmd_valid,
    output logic [1:0] o_cmd,
    output logic       o_abort,
    output logic       o_tick,
    output logic       o_busy,
    output logic [2:0] o_pend,
    output logic       o_err
);
    localparam int            DW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam int            TW       = $clog2(MAX_TICKS + 1);
    localparam logic [TW-1:0] T_LAST   = TW'(MAX_TICKS - 1);

    logic rise_l, rise_r, rise_h;

    tbird_debounce #(.DB_LEN(DB_LEN)) u_db_left  (.i_clk(i_clk), .i_rst(i_rst), .sw(i_sw_left),  .rise(rise_l));
    tbird_debounce #(.DB_LEN(DB_LEN)) u_db_right (.i_clk(i_clk), .i_rst(i_rst), .sw(i_sw_right), .rise(rise_r));
    tbird_debounce #(.DB_LEN(DB_LEN)) u_db_haz   (.i_clk(i_clk), .i_rst(i_rst), .sw(i_sw_haz),   .rise(rise_h));

    state_t        state;
    cmd_t          cmd_q;
    cmd_t          act_q;
    logic [2:0]    pend;
    logic          rr_right;
    logic [DW-1:0] div_cnt;
    logic [TW-1:0] tcnt;
    logic          valid_q, abort_q, tick_q, busy_q, err_q;

    logic [2:0]    edges, block, set_mask, clr_mask;
    logic          xfer;
    logic [DW-1:0] div_nxt;

    always_comb begin
        edges    = {rise_h, rise_r, rise_l};
        xfer     = (state == ST_ISSUE) && i_cmd_ready;
        // The running source's own edges are dropped; a finishing sequence
        // (seq_done this cycle) no longer counts as running.
        block    = ((state == ST_ACTIVE) && !i_seq_done) ? cmd_mask(act_q) : 3'b000;
        set_mask = edges & ~block;
        clr_mask = xfer ? cmd_mask(cmd_q) : 3'b000;
        // Restart the step period on acceptance so the first step is full length.
        if (xfer || (div_cnt == DIV_LAST)) begin
            div_nxt = '0;
        end else begin
            div_nxt = div_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            cmd_q    <= CMD_NONE;
            act_q    <= CMD_NONE;
            pend     <= '0;
            rr_right <= 1'b0;
            div_cnt  <= '0;
            tcnt     <= '0;
            valid_q  <= 1'b0;
            abort_q  <= 1'b0;
            tick_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            tick_q  <= (div_nxt == DIV_LAST);
            pend    <= (pend | set_mask) & ~clr_mask;
            abort_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|pend) begin
                        state   <= ST_ISSUE;
                        valid_q <= 1'b1;
                        cmd_q   <= pick_cmd(pend, rr_right);
                    end
                end
                ST_ISSUE: begin
                    if (i_cmd_ready) begin
                        state   <= ST_ACTIVE;
                        valid_q <= 1'b0;
                        cmd_q   <= CMD_NONE;
                        act_q   <= cmd_q;
                        busy_q  <= 1'b1;
                        tcnt    <= '0;
                        // Pointer moves only when the other side was also waiting.
                        if (cmd_q == CMD_LEFT && pend[SRC_RIGHT]) begin
                            rr_right <= 1'b1;
                        end else if (cmd_q == CMD_RIGHT && pend[SRC_LEFT]) begin
                            rr_right <= 1'b0;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (i_seq_done) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else if (rise_h) begin
                        // Preempts LEFT/RIGHT, or cancels a running HAZ.
                        state   <= ST_ABORT;
                        abort_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (tick_q) begin
                        if (tcnt == T_LAST) begin
                            state   <= ST_ABORT;
                            abort_q <= 1'b1;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                end
                ST_ABORT: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign o_cmd_valid = valid_q;
    assign o_cmd       = cmd_q;
    assign o_abort     = abort_q;
    assign o_tick      = tick_q;
    assign o_busy      = busy_q;
    assign o_pend      = pend;
    assign o_err       = err_q;

endmodule

// File: tb/tb_tbird_sched.sv
// Directed self-checking bench for tbird_sched (TICK_DIV=8, DB_LEN=4, MAX_TICKS=8).
// Inputs driven and outputs sampled 1 time unit after each rising clock edge.
module tb_tbird_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       sw_left, sw_right, sw_haz;
    logic       cmd_ready, seq_done;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       abort, tick, busy, err;
    logic [2:0] pend;

    int n_cmp = 0;
    int n_bad = 0;

    tbird_sched #(
        .TICK_DIV (8),
        .DB_LEN   (4),
        .MAX_TICKS(8)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_sw_left  (sw_left),
        .i_sw_right (sw_right),
        .i_sw_haz   (sw_haz),
        .i_cmd_ready(cmd_ready),
        .i_seq_done (seq_done),
        .o_cmd_valid(cmd_valid),
        .o_cmd      (cmd),
        .o_abort    (abort),
        .o_tick     (tick),
        .o_busy     (busy),
        .o_pend     (pend),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        seq_done = 1'b1;
        step(1);
        seq_done = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(cmd_valid), 0);
        check({tag, "_cmd"},   32'(cmd),       0);
        check({tag, "_abort"}, 32'(abort),     0);
        check({tag, "_tick"},  32'(tick),      0);
        check({tag, "_busy"},  32'(busy),      0);
        check({tag, "_pend"},  32'(pend),      0);
        check({tag, "_err"},   32'(err),       0);
    endtask

    initial begin
        int bad;
        rst = 1'b1; sw_left = 1'b0; sw_right = 1'b0; sw_haz = 1'b0;
        cmd_ready = 1'b1; seq_done = 1'b0;
        step(2);
        check_all_zero("rst");
        rst = 1'b0;

        // Tick strobe: count 0..7, strobe when count is 7.
        step(6); check("tick_before", 32'(tick), 0);
        step(1); check("tick_at7",    32'(tick), 1);
        step(1); check("tick_clear",  32'(tick), 0);

        // Left press: command appears exactly 9 cycles after the raw rise.
        sw_left = 1'b1;
        step(8); check("l_lat8_valid", 32'(cmd_valid), 0);
        step(1); check("l_lat9_valid", 32'(cmd_valid), 1);
        check("l_cmd",  32'(cmd),  1);
        check("l_pend", 32'(pend), 1);
        step(1); check("l_busy", 32'(busy), 1);
        check("l_valid_off", 32'(cmd_valid), 0);
        check("l_pend_clr",  32'(pend),      0);
        sw_left = 1'b0;
        pulse_done();
        check("l_done_idle", 32'(busy), 0);
        step(10);

        // Left and right together: LEFT first, then RIGHT.
        sw_left = 1'b1; sw_right = 1'b1;
        step(9); check("lr1_first", 32'(cmd), 1);
        step(1); check("lr1_busy", 32'(busy), 1);
        check("lr1_pend_r", 32'(pend), 2);
        pulse_done();
        check("lr1_idle", 32'(cmd_valid), 0);
        step(1); check("lr1_second_valid", 32'(cmd_valid), 1);
        check("lr1_second", 32'(cmd), 2);
        step(1); check("lr1_second_busy", 32'(busy), 1);
        sw_left = 1'b0; sw_right = 1'b0;
        pulse_done();
        step(10);
        // Repeat: round-robin now favours RIGHT.
        sw_left = 1'b1; sw_right = 1'b1;
        step(9); check("lr2_first", 32'(cmd), 2);
        step(1);
        pulse_done();
        step(1); check("lr2_second", 32'(cmd), 1);
        step(1);
        sw_left = 1'b0; sw_right = 1'b0;
        pulse_done();
        step(10);

        // Hazard preempts a running LEFT, then issues.
        sw_left = 1'b1;
        step(9); check("hz_left", 32'(cmd), 1);
        step(1);
        sw_left = 1'b0; sw_haz = 1'b1;
        step(8); check("hz_abort", 32'(abort), 1);
        check("hz_busy_drop", 32'(busy), 0);
        check("hz_pend",      32'(pend), 4);
        step(1); check("hz_abort_1cyc", 32'(abort), 0);
        step(1); check("hz_issue_valid", 32'(cmd_valid), 1);
        check("hz_issue_cmd", 32'(cmd), 3);
        step(1); check("hz_busy", 32'(busy), 1);
        sw_haz = 1'b0;
        step(10);
        // Second hazard press cancels the running HAZ.
        sw_haz = 1'b1;
        step(8); check("hz_cancel_abort", 32'(abort), 1);
        step(1); check("hz_cancel_pend", 32'(pend), 0);
        check("hz_cancel_busy", 32'(busy), 0);
        sw_haz = 1'b0;
        step(1); check("hz_cancel_idle", 32'(cmd_valid), 0);
        step(10);

        // Back-pressure: offer held stable for 20 cycles; stray done ignored.
        cmd_ready = 1'b0;
        sw_right = 1'b1;
        step(9); check("bp_valid", 32'(cmd_valid), 1);
        check("bp_cmd", 32'(cmd), 2);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            seq_done = (i == 5);
            step(1);
            if (cmd_valid !== 1'b1 || cmd !== 2'd2 || pend !== 3'b010 || busy !== 1'b0) bad++;
        end
        seq_done = 1'b0;
        check("bp_hold_stable", 32'(bad), 0);
        cmd_ready = 1'b1;
        step(1); check("bp_xfer_busy", 32'(busy), 1);
        check("bp_xfer_valid", 32'(cmd_valid), 0);
        check("bp_xfer_pend",  32'(pend),      0);
        sw_right = 1'b0;
        pulse_done();
        step(10);

        // Timeout: 8 ticks (64 cycles) in ACTIVE without done.
        sw_left = 1'b1;
        step(9); check("to_valid", 32'(cmd_valid), 1);
        step(1); check("to_busy", 32'(busy), 1);
        sw_left = 1'b0;
        step(63); check("to_abort_early", 32'(abort), 0);
        check("to_err_early", 32'(err), 0);
        check("to_busy_held", 32'(busy), 1);
        step(1); check("to_abort", 32'(abort), 1);
        check("to_err",  32'(err),  1);
        check("to_busy", 32'(busy), 0);
        step(10); check("to_err_sticky", 32'(err), 1);
        check("to_abort_gone", 32'(abort), 0);

        // 3-cycle glitch is rejected; 4-cycle pulse is accepted.
        sw_right = 1'b1;
        step(3);
        sw_right = 1'b0;
        step(15); check("gl_pend", 32'(pend), 0);
        check("gl_valid", 32'(cmd_valid), 0);
        sw_right = 1'b1;
        step(4);
        sw_right = 1'b0;
        step(5); check("gl4_valid", 32'(cmd_valid), 1);
        check("gl4_cmd", 32'(cmd), 2);
        step(1);
        pulse_done();
        step(10);

        // Reset while a command is being offered.
        cmd_ready = 1'b0;
        sw_left = 1'b1;
        step(9); check("ri_valid", 32'(cmd_valid), 1);
        check("ri_err_before", 32'(err), 1);
        rst = 1'b1;
        step(1);
        check_all_zero("ri");
        rst = 1'b0; sw_left = 1'b0; cmd_ready = 1'b1;
        step(1); check("ri_after_valid", 32'(cmd_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
